// File: rtl/afifo_pkg.sv
// Shared async-FIFO definitions: default address width and Gray/binary conversions.
// Functions work on a 32-bit container; width selects how many low bits are meaningful.
package afifo_pkg;

    localparam int ADD_WIDTH_DEF = 3;
    localparam int CONV_W        = 32;

    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] bin,
                                                   input int unsigned width);
        logic [CONV_W-1:0] mask;
        mask = (width >= CONV_W) ? '1 : ((CONV_W'(1) << width) - CONV_W'(1));
        return (bin ^ (bin >> 1)) & mask;
    endfunction

    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] gray,
                                                   input int unsigned width);
        logic [CONV_W-1:0] bin;
        logic              acc;
        bin = '0;
        acc = 1'b0;
        for (int i = CONV_W - 1; i >= 0; i--) begin
            if (i < int'(width)) begin
                acc    = acc ^ gray[i];
                bin[i] = acc;
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/read_ptr_empty_if.sv
// Read-side pointer bundle between the read port logic and the pointer/empty block.
// rd_almost_empty exists only when RD_ALMOST_EMPTY_EN is defined.
interface read_ptr_empty_if #(
    parameter int ADD_WIDTH = afifo_pkg::ADD_WIDTH_DEF
);
    logic                 rd_en;
    logic [ADD_WIDTH:0]   rd_sync_wptr;
    logic [ADD_WIDTH-1:0] rd_addr;
    logic [ADD_WIDTH:0]   rd_ptr_gray;
    logic                 rd_empty;
    logic [ADD_WIDTH:0]   rd_level;
    logic                 rd_underflow;
`ifdef RD_ALMOST_EMPTY_EN
    logic                 rd_almost_empty;

    modport master (
        output rd_en, rd_sync_wptr,
        input  rd_addr, rd_ptr_gray, rd_empty, rd_level, rd_underflow, rd_almost_empty
    );
    modport slave (
        input  rd_en, rd_sync_wptr,
        output rd_addr, rd_ptr_gray, rd_empty, rd_level, rd_underflow, rd_almost_empty
    );
`else
    modport master (
        output rd_en, rd_sync_wptr,
        input  rd_addr, rd_ptr_gray, rd_empty, rd_level, rd_underflow
    );
    modport slave (
        input  rd_en, rd_sync_wptr,
        output rd_addr, rd_ptr_gray, rd_empty, rd_level, rd_underflow
    );
`endif
endinterface

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
// Zero latency; no flow control.
module gray2bin_conv #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);
    logic acc;

    always_comb begin
        bin = '0;
        acc = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            acc    = acc ^ gray[i];
            bin[i] = acc;
        end
    end

endmodule

// File: rtl/read_ptr_empty.sv
// Async FIFO read-domain pointer, registered empty flag and occupancy. Optional almost-empty via RD_ALMOST_EMPTY_EN.
// Latency: outputs update on the edge that accepts a read; a synchronised write-pointer change shows 1 cycle later.
module read_ptr_empty
    import afifo_pkg::*;
#(
    parameter int ADD_WIDTH       = ADD_WIDTH_DEF,
    parameter int ALMOST_EMPTY_TH = 1
) (
    input  logic            rd_clk,
    input  logic            rd_rst,
    read_ptr_empty_if.slave bus
);
    localparam int PTR_W = ADD_WIDTH + 1;

    if (ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > (1 << ADD_WIDTH)) begin : g_bad_th
        $error("ALMOST_EMPTY_TH out of range 0..2^ADD_WIDTH");
    end

    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rgray_q;
    logic             empty_q;
    logic [PTR_W-1:0] level_q;
    logic             underflow_q;

    logic             accept;
    logic [PTR_W-1:0] rbin_next;
    logic [PTR_W-1:0] rgray_next;
    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] level_next;

    gray2bin_conv #(.W(PTR_W)) u_wptr_conv (
        .gray (bus.rd_sync_wptr),
        .bin  (wbin)
    );

    always_comb begin
        accept     = bus.rd_en & ~empty_q;
        rbin_next  = accept ? rbin + PTR_W'(1) : rbin;
        rgray_next = rbin_next ^ (rbin_next >> 1);
        // Modulo subtraction keeps level correct across the pointer wrap.
        level_next = wbin - rbin_next;
    end

`ifdef RD_ALMOST_EMPTY_EN
    logic almost_empty_q;

    always_ff @(posedge rd_clk) begin
        if (!rd_rst) begin
            rbin           <= '0;
            rgray_q        <= '0;
            empty_q        <= 1'b1;
            level_q        <= '0;
            underflow_q    <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            rbin           <= rbin_next;
            rgray_q        <= rgray_next;
            empty_q        <= (rgray_next == bus.rd_sync_wptr);
            level_q        <= level_next;
            underflow_q    <= underflow_q | (bus.rd_en & empty_q);
            almost_empty_q <= (level_next <= PTR_W'(ALMOST_EMPTY_TH));
        end
    end

    assign bus.rd_almost_empty = almost_empty_q;
`else
    always_ff @(posedge rd_clk) begin
        if (!rd_rst) begin
            rbin        <= '0;
            rgray_q     <= '0;
            empty_q     <= 1'b1;
            level_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            rbin        <= rbin_next;
            rgray_q     <= rgray_next;
            empty_q     <= (rgray_next == bus.rd_sync_wptr);
            level_q     <= level_next;
            underflow_q <= underflow_q | (bus.rd_en & empty_q);
        end
    end
`endif

    assign bus.rd_addr      = rbin[ADD_WIDTH-1:0];
    assign bus.rd_ptr_gray  = rgray_q;
    assign bus.rd_empty     = empty_q;
    assign bus.rd_level     = level_q;
    assign bus.rd_underflow = underflow_q;

endmodule

// File: tb/tb_read_ptr_empty.sv
// Directed bench for read_ptr_empty (ADD_WIDTH=3); almost-empty checks only with RD_ALMOST_EMPTY_EN.
module tb_read_ptr_empty;
    import afifo_pkg::*;

    localparam int AW = 3;

    logic rd_clk = 1'b0;
    logic rd_rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    read_ptr_empty_if #(.ADD_WIDTH(AW)) bus ();

    read_ptr_empty #(.ADD_WIDTH(AW), .ALMOST_EMPTY_TH(1)) dut (
        .rd_clk (rd_clk),
        .rd_rst (rd_rst),
        .bus    (bus)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    function automatic logic [AW:0] gw(input int b);
        logic [31:0] g;
        g = bin2gray(32'(b), AW + 1);
        return g[AW:0];
    endfunction

    task automatic check_ae(input string tag, input logic exp);
`ifdef RD_ALMOST_EMPTY_EN
        check(tag, 32'(bus.rd_almost_empty), 32'(exp));
`else
        if (tag.len() == 0 && exp) n_tests += 0;
`endif
    endtask

    initial begin
        bus.rd_en        = 1'b0;
        bus.rd_sync_wptr = '0;
        rd_rst           = 1'b0;
        step();
        step();
        check("rst_empty", 32'(bus.rd_empty), 32'd1);
        check("rst_addr",  32'(bus.rd_addr), 32'd0);
        check("rst_gray",  32'(bus.rd_ptr_gray), 32'd0);
        check("rst_level", 32'(bus.rd_level), 32'd0);
        check("rst_uf",    32'(bus.rd_underflow), 32'd0);
        check_ae("rst_ae", 1'b1);
        rd_rst = 1'b1;

        // Two entries become visible.
        bus.rd_sync_wptr = 4'b0011;
        step();
        check("fill_empty", 32'(bus.rd_empty), 32'd0);
        check("fill_level", 32'(bus.rd_level), 32'd2);

        bus.rd_en = 1'b1;
        step();
        check("rd1_addr",  32'(bus.rd_addr), 32'd1);
        check("rd1_gray",  32'(bus.rd_ptr_gray), 32'b0001);
        check("rd1_empty", 32'(bus.rd_empty), 32'd0);
        check("rd1_level", 32'(bus.rd_level), 32'd1);
        step();
        check("rd2_addr",  32'(bus.rd_addr), 32'd2);
        check("rd2_gray",  32'(bus.rd_ptr_gray), 32'b0011);
        check("rd2_empty", 32'(bus.rd_empty), 32'd1);
        check("rd2_level", 32'(bus.rd_level), 32'd0);

        // Read while empty.
        step();
        check("uf_addr", 32'(bus.rd_addr), 32'd2);
        check("uf_gray", 32'(bus.rd_ptr_gray), 32'b0011);
        check("uf_set",  32'(bus.rd_underflow), 32'd1);
        bus.rd_en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("uf_sticky", 32'(bus.rd_underflow), 32'd1);
        check("uf_addr2",  32'(bus.rd_addr), 32'd2);

        // Back to rbin=0, then full and wrap.
        rd_rst = 1'b0;
        bus.rd_sync_wptr = 4'b0000;
        step();
        check("rst2_uf",   32'(bus.rd_underflow), 32'd0);
        check("rst2_addr", 32'(bus.rd_addr), 32'd0);
        rd_rst = 1'b1;
        bus.rd_sync_wptr = 4'b1100;
        step();
        check("full_level", 32'(bus.rd_level), 32'd8);
        check("full_empty", 32'(bus.rd_empty), 32'd0);
        bus.rd_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("drain1_lvl%0d", i), 32'(bus.rd_level), 32'(8 - i));
        end
        bus.rd_en = 1'b0;
        check("drain1_gray",  32'(bus.rd_ptr_gray), 32'b1100);
        check("drain1_empty", 32'(bus.rd_empty), 32'd1);
        check("drain1_addr",  32'(bus.rd_addr), 32'd0);

        bus.rd_sync_wptr = 4'b0000;
        step();
        check("full2_level", 32'(bus.rd_level), 32'd8);
        check("full2_empty", 32'(bus.rd_empty), 32'd0);
        bus.rd_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("drain2_addr%0d", i), 32'(bus.rd_addr), 32'(i % 8));
        end
        bus.rd_en = 1'b0;
        check("wrap_gray",  32'(bus.rd_ptr_gray), 32'b0000);
        check("wrap_empty", 32'(bus.rd_empty), 32'd1);
        check("wrap_level", 32'(bus.rd_level), 32'd0);

        // Read and write in the same cycle; rbin=0 here.
        bus.rd_sync_wptr = gw(1);
        step();
        check("simul_pre_level", 32'(bus.rd_level), 32'd1);
        bus.rd_en = 1'b1;
        bus.rd_sync_wptr = gw(2);
        step();
        check("simul_level", 32'(bus.rd_level), 32'd1);
        check("simul_empty", 32'(bus.rd_empty), 32'd0);
        check("simul_gray",  32'(bus.rd_ptr_gray), 32'b0001);
        step();
        check("simul_last_empty", 32'(bus.rd_empty), 32'd1);
        check("simul_last_addr",  32'(bus.rd_addr), 32'd2);
        bus.rd_en = 1'b0;

        // Almost-empty thresholds from level 3 (rbin=2, wbin=5).
        bus.rd_sync_wptr = gw(5);
        step();
        check("ae_l3", 32'(bus.rd_level), 32'd3);
        check_ae("ae_f3", 1'b0);
        bus.rd_en = 1'b1;
        step();
        check("ae_l2", 32'(bus.rd_level), 32'd2);
        check_ae("ae_f2", 1'b0);
        step();
        check("ae_l1", 32'(bus.rd_level), 32'd1);
        check_ae("ae_f1", 1'b1);
        step();
        check("ae_l0", 32'(bus.rd_level), 32'd0);
        check("ae_e0", 32'(bus.rd_empty), 32'd1);
        check_ae("ae_f0", 1'b1);
        step();
        check("uf2_set", 32'(bus.rd_underflow), 32'd1);
        bus.rd_en = 1'b0;

        // Reset during active reads (rbin=5, wbin=7).
        bus.rd_sync_wptr = gw(7);
        step();
        check("pre_rst_level", 32'(bus.rd_level), 32'd2);
        bus.rd_en = 1'b1;
        rd_rst = 1'b0;
        step();
        check("mid_rst_addr",  32'(bus.rd_addr), 32'd0);
        check("mid_rst_gray",  32'(bus.rd_ptr_gray), 32'd0);
        check("mid_rst_level", 32'(bus.rd_level), 32'd0);
        check("mid_rst_empty", 32'(bus.rd_empty), 32'd1);
        check("mid_rst_uf",    32'(bus.rd_underflow), 32'd0);
        check_ae("mid_rst_ae", 1'b1);
        rd_rst = 1'b1;
        bus.rd_en = 1'b0;
        step();
        check("post_rst_level", 32'(bus.rd_level), 32'd7);
        check("post_rst_empty", 32'(bus.rd_empty), 32'd0);

        // A reset pulse between edges must be ignored.
        rd_rst = 1'b0;
        #3;
        rd_rst = 1'b1;
        step();
        check("glitch_level", 32'(bus.rd_level), 32'd7);
        check("glitch_empty", 32'(bus.rd_empty), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
